load_store_unit: RTL

CPU-side initiator for data memory. Takes one load or store per transaction from the execute stage (RISC-V func3 encoding for LB/LH/LW/LBU/LHU/SB/SH/SW), drives a word-aligned, byte-enabled request/acknowledge interface toward data memory, and returns a sign- or zero-extended load result. Misaligned halfword and word accesses are supported in hardware: an access that crosses a 4-byte boundary is split into two aligned memory beats. The block sits between the CPU core's memory stage and the data RAM, replacing direct combinational RAM addressing.

---
 rtl/load_store_unit_if.sv | 39 +++
 rtl/load_store_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// CPU request/response and data-memory beat signals of the load/store unit.
// The unit itself takes the slave view; the driving environment takes master.
interface load_store_unit_if #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
);
    logic                 reqValid;
    logic                 reqReady;
    logic                 reqWrite;
    logic [2:0]           func3;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] writeData;
    logic                 respValid;
    logic                 respError;
    logic [DataWidth-1:0] readData;
    logic                 memReq;
    logic                 memWriteEnable;
    logic [AddrWidth-1:0] memAddr;
    logic [3:0]           memByteEnable;
    logic [DataWidth-1:0] memWriteData;
    logic                 memAck;
    logic [DataWidth-1:0] memReadData;

    modport master (
        output reqValid, reqWrite, func3, addr, writeData,
        output memAck, memReadData,
        input  reqReady, respValid, respError, readData,
        input  memReq, memWriteEnable, memAddr,
        input  memByteEnable, memWriteData
    );

    modport slave (
        input  reqValid, reqWrite, func3, addr, writeData,
        input  memAck, memReadData,
        output reqReady, respValid, respError, readData,
        output memReq, memWriteEnable, memAddr,
        output memByteEnable, memWriteData
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one CPU access per transaction, split into at most two
// word-aligned memory beats when it crosses a 4-byte boundary.
module load_store_unit #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
) (
    input logic clk,
    input logic rstn,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_e;

    state_e               state_q, state_d;
    logic                 write_q, write_d;
    logic [2:0]           f3_q, f3_d;
    logic [1:0]           off_q, off_d;
    logic [3:0]           hiBe_q, hiBe_d;
    logic [DataWidth-1:0] hiWd_q, hiWd_d;
    logic [DataWidth-1:0] lo_q, lo_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [3:0]           be_q, be_d;
    logic                 we_q, we_d;
    logic [DataWidth-1:0] wd_q, wd_d;
    logic                 rv_q, rv_d;
    logic                 re_q, re_d;
    logic [DataWidth-1:0] rd_q, rd_d;

    logic                   legal;
    logic [3:0]             szMask;
    logic [7:0]             reqMask;
    logic [2*DataWidth-1:0] reqWd;

    function automatic logic [DataWidth-1:0] extend(
        input logic [2:0]             f3,
        input logic [1:0]             off,
        input logic [2*DataWidth-1:0] pair
    );
        logic [2*DataWidth-1:0] sh;
        logic [DataWidth-1:0]   r;
        sh = pair >> {off, 3'b000};
        unique case (f3)
            3'd0:    r = {{24{sh[7]}}, sh[7:0]};
            3'd1:    r = {{16{sh[15]}}, sh[15:0]};
            3'd4:    r = {24'b0, sh[7:0]};
            3'd5:    r = {16'b0, sh[15:0]};
            default: r = sh[DataWidth-1:0];
        endcase
        return r;
    endfunction

    always_comb begin
        if (bus.reqWrite) legal = bus.func3 inside {3'd0, 3'd1, 3'd2};
        else legal = bus.func3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        unique case (bus.func3[1:0])
            2'd0:    szMask = 4'b0001;
            2'd1:    szMask = 4'b0011;
            default: szMask = 4'b1111;
        endcase
        // upper nibble / upper word describe the second beat of a split
        reqMask = {4'b0000, szMask} << bus.addr[1:0];
        reqWd = {{DataWidth{1'b0}}, bus.writeData} << {bus.addr[1:0], 3'b000};
    end

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        f3_d    = f3_q;
        off_d   = off_q;
        hiBe_d  = hiBe_q;
        hiWd_d  = hiWd_q;
        lo_d    = lo_q;
        addr_d  = addr_q;
        be_d    = be_q;
        we_d    = we_q;
        wd_d    = wd_q;
        rv_d    = 1'b0;
        re_d    = 1'b0;
        rd_d    = rd_q;
        unique case (state_q)
            IDLE: begin
                if (bus.reqValid) begin
                    write_d = bus.reqWrite;
                    f3_d    = bus.func3;
                    off_d   = bus.addr[1:0];
                    if (legal) begin
                        addr_d  = {bus.addr[AddrWidth-1:2], 2'b00};
                        be_d    = reqMask[3:0];
                        we_d    = bus.reqWrite;
                        wd_d    = reqWd[DataWidth-1:0];
                        hiBe_d  = reqMask[7:4];
                        hiWd_d  = reqWd[2*DataWidth-1:DataWidth];
                        state_d = BEAT0;
                    end else begin
                        rv_d    = 1'b1;
                        re_d    = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            BEAT0: begin
                if (bus.memAck) begin
                    lo_d = bus.memReadData;
                    if (hiBe_q != 4'b0000) begin
                        addr_d  = addr_q + AddrWidth'(4);
                        be_d    = hiBe_q;
                        wd_d    = hiWd_q;
                        state_d = BEAT1;
                    end else begin
                        rv_d = 1'b1;
                        if (!write_q)
                            rd_d = extend(f3_q, off_q,
                                {{DataWidth{1'b0}}, bus.memReadData});
                        state_d = DONE;
                    end
                end
            end
            BEAT1: begin
                if (bus.memAck) begin
                    rv_d = 1'b1;
                    if (!write_q)
                        rd_d = extend(f3_q, off_q, {bus.memReadData, lo_q});
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            hiBe_q  <= 4'd0;
            hiWd_q  <= '0;
            lo_q    <= '0;
            addr_q  <= '0;
            be_q    <= 4'd0;
            we_q    <= 1'b0;
            wd_q    <= '0;
            rv_q    <= 1'b0;
            re_q    <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            hiBe_q  <= hiBe_d;
            hiWd_q  <= hiWd_d;
            lo_q    <= lo_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            we_q    <= we_d;
            wd_q    <= wd_d;
            rv_q    <= rv_d;
            re_q    <= re_d;
            rd_q    <= rd_d;
        end
    end

    assign bus.reqReady       = (state_q == IDLE);
    assign bus.memReq         = (state_q == BEAT0) || (state_q == BEAT1);
    assign bus.memAddr        = addr_q;
    assign bus.memByteEnable  = be_q;
    assign bus.memWriteEnable = we_q;
    assign bus.memWriteData   = wd_q;
    assign bus.respValid      = rv_q;
    assign bus.respError      = re_q;
    assign bus.readData       = rd_q;
endmodule
